// File: rtl/gpc_accum.sv
// Generalized parallel counter feeding a saturating frame accumulator.
// Two-stage valid/ready pipeline: stage 1 holds the beat sum, stage 2 the accumulator and result.
module gpc_accum #(
    parameter int unsigned N0    = 6,
    parameter int unsigned N2    = 2,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N0-1:0]    src0,
    input  logic [N2-1:0]    src2,
    input  logic             acc_en,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] dst,
    output logic             out_ovf
);
    localparam int unsigned SUM_W = $clog2(N0 + 4 * N2 + 1);
    localparam int unsigned EXT_W = ACC_W + 1;

    logic [SUM_W-1:0] beat_sum;
    logic             s1_valid_q, s1_valid_d;
    logic [SUM_W-1:0] s1_sum_q, s1_sum_d;
    logic             s1_acc_q, s1_acc_d;
    logic             s1_last_q, s1_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             facc_ovf_q, facc_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] dst_q, dst_d;
    logic             out_ovf_q, out_ovf_d;
    logic             s2_free, s1_adv, in_accept;
    logic [EXT_W-1:0] add_full;
    logic [ACC_W-1:0] add_sat;

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < int'(N0); i++) begin
            beat_sum = beat_sum + SUM_W'(src0[i]);
        end
        for (int i = 0; i < int'(N2); i++) begin
            beat_sum = beat_sum + (src2[i] ? SUM_W'(4) : '0);
        end
    end

    // in_ready depends only on state and out_ready; reset holds it low.
    assign s2_free   = !out_valid_q || out_ready;
    assign s1_adv    = s1_valid_q && s2_free;
    assign in_ready  = rst_n && (!s1_valid_q || s2_free);
    assign in_accept = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_acc_d   = s1_acc_q;
        s1_last_d  = s1_last_q;
        if (in_accept) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = beat_sum;
            s1_acc_d   = acc_en;
            s1_last_d  = in_last;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    assign add_full = {1'b0, acc_q} + EXT_W'(s1_sum_q);
    assign add_sat  = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];

    always_comb begin
        acc_d       = acc_q;
        facc_ovf_d  = facc_ovf_q;
        out_valid_d = out_valid_q && !out_ready;
        dst_d       = dst_q;
        out_ovf_d   = out_ovf_q;
        if (s1_adv) begin
            if (!s1_acc_q) begin
                out_valid_d = 1'b1;
                dst_d       = ACC_W'(s1_sum_q);
                out_ovf_d   = 1'b0;
            end else if (!s1_last_q) begin
                acc_d      = add_sat;
                facc_ovf_d = facc_ovf_q | add_full[ACC_W];
            end else begin
                out_valid_d = 1'b1;
                dst_d       = add_sat;
                out_ovf_d   = facc_ovf_q | add_full[ACC_W];
                acc_d       = '0;
                facc_ovf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_acc_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            facc_ovf_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dst_q       <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_acc_q    <= s1_acc_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            facc_ovf_q  <= facc_ovf_d;
            out_valid_q <= out_valid_d;
            dst_q       <= dst_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dst       = dst_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_gpc_accum.sv
// Scoreboard bench for gpc_accum: a 12-bit and a 5-bit instance share stimulus, and a
// reference model built from popcounts and saturating integer sums predicts both.
module tb_gpc_accum;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, acc_en, in_last, out_ready;
    logic [5:0]  src0;
    logic [1:0]  src2;
    logic        in_ready_a, out_valid_a, ovf_a;
    logic [11:0] dst_a;
    logic        in_ready_b, out_valid_b, ovf_b;
    logic [4:0]  dst_b;

    gpc_accum #(.N0(6), .N2(2), .ACC_W(12)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .src0(src0), .src2(src2), .acc_en(acc_en), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .dst(dst_a), .out_ovf(ovf_a)
    );

    gpc_accum #(.N0(6), .N2(2), .ACC_W(5)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .src0(src0), .src2(src2), .acc_en(acc_en), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .dst(dst_b), .out_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit o;
        int c;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   or_mode = 0;
    bit   chk_lat = 1'b0;
    bit   saw_block = 1'b0;
    int   acc_m[2];
    bit   ovf_m[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: frame sums are plain integers clamped to each instance's maximum.
    task automatic model_beat(input int s, input bit ae, input bit last, input int c);
        int maxv[2];
        maxv[0] = 4095;
        maxv[1] = 31;
        for (int w = 0; w < 2; w++) begin
            exp_t e;
            int   t;
            e.c = c;
            t = acc_m[w] + s;
            if (!ae) begin
                e.d = s;
                e.o = 1'b0;
                if (w == 0) q_a.push_back(e); else q_b.push_back(e);
            end else if (!last) begin
                acc_m[w] = (t > maxv[w]) ? maxv[w] : t;
                ovf_m[w] = ovf_m[w] | (t > maxv[w]);
            end else begin
                e.d = (t > maxv[w]) ? maxv[w] : t;
                e.o = ovf_m[w] | (t > maxv[w]);
                if (w == 0) q_a.push_back(e); else q_b.push_back(e);
                acc_m[w] = 0;
                ovf_m[w] = 1'b0;
            end
        end
    endtask

    task automatic send_beat(input logic [5:0] s0, input logic [1:0] s2, input bit ae,
                             input bit last, output int waits);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        src0     = s0;
        src2     = s2;
        acc_en   = ae;
        in_last  = last;
        waits    = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready_a) begin
                model_beat($countones(s0) + 4 * $countones(s2), ae, last, cyc);
                accepted = 1'b1;
                break;
            end
            waits++;
        end
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 64 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        q_a.delete();
        q_b.delete();
    endtask

    // Consumer ready: 0 always ready, 1 random, 2 three-cycle stall at first result, else stalled.
    initial begin
        int left;
        bit fired;
        left      = 0;
        fired     = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: begin
                    out_ready = 1'b1;
                    fired     = 1'b0;
                end
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!fired && out_valid_a) begin
                        left  = 3;
                        fired = 1'b1;
                    end
                    if (left > 0) begin
                        out_ready = 1'b0;
                        left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expectations on every transfer and checks hold behaviour while stalled.
    initial begin
        logic [11:0] pd;
        logic        po;
        bit          pstall;
        exp_t        e;
        pstall = 1'b0;
        pd     = '0;
        po     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    chk("hold_valid", int'(out_valid_a), 1);
                    chk("hold_dst", int'(dst_a), int'(pd));
                    chk("hold_ovf", int'(ovf_a), int'(po));
                end
                if (or_mode == 2 && !in_ready_a) saw_block = 1'b1;
                if (out_valid_a && out_ready) begin
                    if (q_a.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_a: dst=%0d with no result pending", dst_a);
                    end else begin
                        e = q_a.pop_front();
                        chk("dst_a", int'(dst_a), e.d);
                        chk("ovf_a", int'(ovf_a), int'(e.o));
                        if (chk_lat) chk("latency", cyc - e.c, 2);
                    end
                end
                if (out_valid_b && out_ready) begin
                    if (q_b.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_b: dst=%0d with no result pending", dst_b);
                    end else begin
                        e = q_b.pop_front();
                        chk("dst_b", int'(dst_b), e.d);
                        chk("ovf_b", int'(ovf_b), int'(e.o));
                    end
                end
                pstall = out_valid_a && !out_ready;
                pd     = dst_a;
                po     = ovf_a;
            end
        end
    end

    initial begin
        int w;
        in_valid = 1'b0;
        acc_en   = 1'b0;
        in_last  = 1'b0;
        src0     = '0;
        src2     = '0;
        acc_m[0] = 0;
        acc_m[1] = 0;
        ovf_m[0] = 1'b0;
        ovf_m[1] = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready_a), 0);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_dst", int'(dst_a), 0);
        chk("rst_ovf", int'(ovf_a), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready_a), 1);
        @(posedge clk);
        #1;

        // Back-to-back single beats at full rate.
        chk_lat = 1'b1;
        send_beat(6'h03, 2'h3, 1'b0, 1'b0, w);
        chk("throughput0", w, 0);
        send_beat(6'h3f, 2'h3, 1'b0, 1'b0, w);
        chk("throughput1", w, 0);
        send_beat(6'h00, 2'h2, 1'b0, 1'b0, w);
        chk("throughput2", w, 0);
        drain();

        // Frames: plain sum, saturating sum, single-beat frame, interleaved single.
        send_beat(6'h3f, 2'h3, 1'b1, 1'b0, w);
        send_beat(6'h0e, 2'h2, 1'b1, 1'b0, w);
        send_beat(6'h05, 2'h0, 1'b1, 1'b1, w);
        send_beat(6'h3f, 2'h3, 1'b1, 1'b0, w);
        send_beat(6'h3f, 2'h3, 1'b1, 1'b0, w);
        send_beat(6'h3f, 2'h3, 1'b1, 1'b1, w);
        send_beat(6'h01, 2'h0, 1'b1, 1'b1, w);
        send_beat(6'h3f, 2'h3, 1'b1, 1'b0, w);
        send_beat(6'h01, 2'h0, 1'b0, 1'b0, w);
        send_beat(6'h00, 2'h2, 1'b1, 1'b1, w);
        drain();

        // Backpressure: consumer stalls three cycles on the first result.
        chk_lat = 1'b0;
        or_mode = 2;
        send_beat(6'h3f, 2'h3, 1'b0, 1'b0, w);
        send_beat(6'h03, 2'h3, 1'b0, 1'b0, w);
        send_beat(6'h00, 2'h2, 1'b0, 1'b0, w);
        send_beat(6'h15, 2'h1, 1'b0, 1'b0, w);
        drain();
        chk("in_ready_drop", int'(saw_block), 1);
        or_mode = 0;
        idle(2);

        // Reset in the middle of an open frame while a result is stalled.
        send_beat(6'h3f, 2'h3, 1'b1, 1'b0, w);
        send_beat(6'h3f, 2'h3, 1'b1, 1'b0, w);
        or_mode = 3;
        send_beat(6'h01, 2'h0, 1'b0, 1'b0, w);
        idle(4);
        chk("pre_rst_valid", int'(out_valid_a), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid_a), 0);
        chk("mid_rst_in_ready", int'(in_ready_a), 0);
        chk("mid_rst_dst", int'(dst_a), 0);
        chk("mid_rst_valid_b", int'(out_valid_b), 0);
        q_a.delete();
        q_b.delete();
        acc_m[0] = 0;
        acc_m[1] = 0;
        ovf_m[0] = 1'b0;
        ovf_m[1] = 1'b0;
        or_mode  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        chk_lat = 1'b1;
        send_beat(6'h07, 2'h1, 1'b1, 1'b1, w);
        drain();
        chk_lat = 1'b0;

        // Random traffic with a randomly stalling consumer.
        or_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send_beat(6'($urandom), 2'($urandom), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0, w);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        or_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
